// File: rtl/seq_pkg.sv
// Shared definitions for the datapath sequencer: FSM state encodings,
// instruction field positions and ULAControl opcodes.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_DONE      = 3'd4
  } seq_state_e;

  typedef enum logic [2:0] {
    ULA_ADD  = 3'd0,
    ULA_SUB  = 3'd1,
    ULA_AND  = 3'd2,
    ULA_OR   = 3'd3,
    ULA_XOR  = 3'd4,
    ULA_SLT  = 3'd5,
    ULA_SHL  = 3'd6,
    ULA_RSVD = 3'd7
  } ula_op_e;

  localparam int OP_LSB      = 13;
  localparam int RD_LSB      = 10;
  localparam int RS1_LSB     = 7;
  localparam int RS2_LSB     = 4;
  localparam int SRC_IMM_BIT = 3;
  localparam int WB_EN_BIT   = 2;

  localparam logic [2:0] OP_RESERVED = ULA_RSVD;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       src_imm;
    logic       wb_en;
  } instr_fields_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational unpacking of a latched 16-bit instruction into its fields,
// plus a legality bit (reserved opcode is illegal).
module instr_decode
  import seq_pkg::*;
(
  input  logic [15:0]   instr,
  output instr_fields_t fields,
  output logic          legal
);

  logic unused_rsvd_bits;
  assign unused_rsvd_bits = ^instr[1:0];

  always_comb begin
    fields         = '0;
    fields.op      = instr[OP_LSB  +: 3];
    fields.rd      = instr[RD_LSB  +: 3];
    fields.rs1     = instr[RS1_LSB +: 3];
    fields.rs2     = instr[RS2_LSB +: 3];
    fields.src_imm = instr[SRC_IMM_BIT];
    fields.wb_en   = instr[WB_EN_BIT];
    legal          = (fields.op != OP_RESERVED);
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle IDLE/DECODE/EXECUTE/WRITEBACK/DONE controller for the 8-bit
// register-file/ULA datapath. Define SEQ_STEP_EN for single-step operation.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              step,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic              rf_we,
  output logic              alu_src_sel,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              done,
  output logic              busy,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired,
  output logic [2:0]        state_dbg
);

  seq_state_e    state;
  logic [15:0]   instr_q;
  instr_fields_t fields;
  logic          legal;
  logic          advance;

`ifdef SEQ_STEP_EN
  assign advance = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign advance     = 1'b1;
`endif

  instr_decode u_instr_decode (
    .instr  (instr_q),
    .fields (fields),
    .legal  (legal)
  );

  // Datapath controls are plain slices of the latched instruction register,
  // so they are flop outputs and stay stable from DECODE through WRITEBACK.
  assign rf_raddr1   = ADDR_W'(fields.rs1);
  assign rf_raddr2   = ADDR_W'(fields.rs2);
  assign rf_waddr    = ADDR_W'(fields.rd);
  assign alu_src_sel = fields.src_imm;
  assign alu_ctrl    = fields.op;
  assign state_dbg   = state;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      instr_ready <= 1'b1;
      rf_we       <= 1'b0;
      wb_data     <= '0;
      zero_flag   <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      illegal     <= 1'b0;
      retired     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (advance) begin
            if (!legal) illegal <= 1'b1;
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (advance) begin
            wb_data   <= alu_result;
            zero_flag <= alu_zero;
            rf_we     <= fields.wb_en && legal;
            state     <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          if (advance) begin
            rf_we   <= 1'b0;
            done    <= 1'b1;
            retired <= retired + CNT_W'(1);
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          rf_we       <= 1'b0;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed vector table, random
// instructions against a per-cycle expectation model, reset and wrap cases.
module tb_datapath_sequencer;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        step = 1'b1;
  logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic        rf_we, alu_src_sel;
  logic [2:0]  alu_ctrl;
  logic [7:0]  alu_result = '0;
  logic        alu_zero = 1'b0;
  logic [7:0]  wb_data;
  logic        zero_flag, done, busy, illegal;
  logic [7:0]  retired;
  logic [2:0]  state_dbg;

  datapath_sequencer #(.DATA_W(8), .ADDR_W(3), .CNT_W(8)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .step(step),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .alu_src_sel(alu_src_sel), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .wb_data(wb_data),
    .zero_flag(zero_flag), .done(done), .busy(busy), .illegal(illegal),
    .retired(retired), .state_dbg(state_dbg)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int failures = 0;

  // Architectural model state
  logic [7:0] m_wb = '0;
  logic       m_z = 1'b0;
  logic       m_ill = 1'b0;
  int         m_ret = 0;

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  res;
    logic        z;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"},   32'(state_dbg), 0);
    chk({tag, "_ready"},   32'(instr_ready), 1);
    chk({tag, "_raddr1"},  32'(rf_raddr1), 0);
    chk({tag, "_raddr2"},  32'(rf_raddr2), 0);
    chk({tag, "_waddr"},   32'(rf_waddr), 0);
    chk({tag, "_we"},      32'(rf_we), 0);
    chk({tag, "_src"},     32'(alu_src_sel), 0);
    chk({tag, "_ctrl"},    32'(alu_ctrl), 0);
    chk({tag, "_wb"},      32'(wb_data), 0);
    chk({tag, "_zero"},    32'(zero_flag), 0);
    chk({tag, "_done"},    32'(done), 0);
    chk({tag, "_busy"},    32'(busy), 0);
    chk({tag, "_illegal"}, 32'(illegal), 0);
    chk({tag, "_retired"}, 32'(retired), 0);
  endtask

  function automatic void model_reset();
    m_wb = '0; m_z = 1'b0; m_ill = 1'b0; m_ret = 0;
  endfunction

  // One full instruction: ALU inputs carry the real result only during the
  // EXECUTE cycle and junk elsewhere, so capture timing is observable.
  task automatic run_instr(input logic [15:0] ins, input logic [7:0] res, input logic z);
    logic [2:0] op, rd, rs1, rs2;
    logic imm, wb, we_exp, ill_exp;
    op = ins[15:13]; rd = ins[12:10]; rs1 = ins[9:7]; rs2 = ins[6:4];
    imm = ins[3]; wb = ins[2];
    we_exp  = wb && (op != 3'b111);
    ill_exp = m_ill || (op == 3'b111);
    instr = 16'($urandom); instr_valid = 1'b0;
    @(negedge iCLK);
    chk("idle_state", 32'(state_dbg), 0);
    chk("idle_ready", 32'(instr_ready), 1);
    instr = ins; instr_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge iCLK);
      if (k == 1) begin instr_valid = 1'b0; instr = 16'($urandom); end
      chk("state", 32'(state_dbg), (k < 5) ? k : 0);
      chk("busy", 32'(busy), 32'(k < 5));
      chk("ready", 32'(instr_ready), 32'(k == 5));
      chk("rf_we", 32'(rf_we), 32'((k == 3) && we_exp));
      chk("done", 32'(done), 32'(k == 4));
      if (k <= 3) begin
        chk("raddr1", 32'(rf_raddr1), 32'(rs1));
        chk("raddr2", 32'(rf_raddr2), 32'(rs2));
        chk("src_sel", 32'(alu_src_sel), 32'(imm));
        chk("alu_ctrl", 32'(alu_ctrl), 32'(op));
      end
      if (k == 3) chk("waddr", 32'(rf_waddr), 32'(rd));
      chk("wb_data", 32'(wb_data), 32'((k >= 3) ? res : m_wb));
      chk("zero_flag", 32'(zero_flag), 32'((k >= 3) ? z : m_z));
      if (k == 1) chk("illegal_prev", 32'(illegal), 32'(m_ill));
      if (k >= 4) chk("illegal", 32'(illegal), 32'(ill_exp));
      if (k == 5) chk("retired", 32'(retired), 32'((m_ret + 1) % 256));
      alu_result = (k == 2) ? res : (res ^ 8'($urandom_range(1, 255)));
      alu_zero   = (k == 2) ? z : ~z;
    end
    m_wb = res; m_z = z; m_ill = ill_exp; m_ret = (m_ret + 1) % 256;
  endtask

  initial begin
    vecs[0] = '{16'b010_011_001_010_0_1_00, 8'h2A, 1'b0};
    vecs[1] = '{16'b001_100_101_110_1_0_00, 8'h55, 1'b0};
    vecs[2] = '{16'b111_010_011_100_0_1_00, 8'h77, 1'b0};
    vecs[3] = '{16'b000_001_010_011_0_1_00, 8'h00, 1'b1};
    vecs[4] = '{16'b011_111_110_101_1_1_11, 8'hC3, 1'b0};
    vecs[5] = '{16'b110_000_111_000_0_1_01, 8'hFF, 1'b0};

    iRST_N = 1'b0;
    repeat (2) @(negedge iCLK);
    check_reset_outputs("reset");
    iRST_N = 1'b1;

    foreach (vecs[i]) run_instr(vecs[i].ins, vecs[i].res, vecs[i].z);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      run_instr(16'($urandom), r, r == 8'h00);
    end

    // Reset asserted during WRITEBACK abandons the write
    @(negedge iCLK);
    instr = 16'b001_101_010_011_0_1_00; instr_valid = 1'b1;
    @(negedge iCLK); instr_valid = 1'b0;
    @(negedge iCLK); alu_result = 8'h99; alu_zero = 1'b0;
    @(negedge iCLK);
    chk("midrst_pre_we", 32'(rf_we), 1);
    chk("midrst_pre_state", 32'(state_dbg), 3);
    iRST_N = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge iCLK);
    iRST_N = 1'b1;

`ifdef SEQ_STEP_EN
    // Single-step: hold in DECODE, then one state per step pulse
    step = 1'b0;
    alu_result = 8'h3C; alu_zero = 1'b0;
    @(negedge iCLK);
    instr = 16'b100_010_001_011_0_1_00; instr_valid = 1'b1;
    @(negedge iCLK); instr_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("step_hold_decode", 32'(state_dbg), 1);
      @(negedge iCLK);
    end
    for (int s = 2; s <= 4; s++) begin
      step = 1'b1;
      @(negedge iCLK);
      step = 1'b0;
      chk("step_advance", 32'(state_dbg), 32'(s));
      if (s < 4) begin
        repeat (3) @(negedge iCLK);
        chk("step_hold", 32'(state_dbg), 32'(s));
        chk("step_we", 32'(rf_we), 32'(s == 3));
      end
    end
    @(negedge iCLK);
    chk("step_idle", 32'(state_dbg), 0);
    chk("step_wb", 32'(wb_data), 8'h3C);
    m_wb = 8'h3C; m_z = 1'b0; m_ret = 1;
    step = 1'b1;
`endif

    for (int i = 0; i < 256; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      run_instr(16'($urandom), r, 1'($urandom));
    end
    chk("retired_wrap", 32'(retired), 32'(m_ret));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle controller for the 8-bit register-file/ULA datapath. Accepts one packed instruction at a time over a valid/ready handshake and sequences the datapath through decode, execute and write-back: it drives register-file read/write addresses and write enable, the SrcB mux select and ULAControl. It also latches the ULA result and Zero flag. It sits between the instruction source (switches/keys or a small program ROM) and the datapath, and exposes status for the LCD/7-segment displays.

## Interface
- DATA_W, 8, datapath width
- ADDR_W, 3, register address width
- CNT_W, 8, retired-instruction counter width

- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- instr  in  16  op[15:13], rd[12:10], rs1[9:7], rs2[6:4], src_imm[3], wb_en[2], [1:0] reserved (ignored)
- step  in  1  advance strobe, single-step mode only
- rf_raddr1  out  ADDR_W  register read port 1 address
- rf_raddr2  out  ADDR_W  register read port 2 address
- rf_waddr  out  ADDR_W  register write address
- rf_we  out  1  register write enable
- alu_src_sel  out  1  SrcB mux select (1 = immediate constant)
- alu_ctrl  out  3  ULAControl
- alu_result  in  DATA_W  ULA result
- alu_zero  in  1  ULA Zero
- wb_data  out  DATA_W  latched result
- zero_flag  out  1  latched Zero
- done  out  1  one-cycle completion pulse
- busy  out  1  not IDLE
- illegal  out  1  sticky reserved-opcode flag
- retired  out  CNT_W  completed-instruction count
- state_dbg  out  3  current state encoding

## Operation
- States: IDLE(0), DECODE(1), EXECUTE(2), WRITEBACK(3), DONE(4).
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE. instr is ignored when instr_valid=0.
- DECODE: drive rf_raddr1=rs1, rf_raddr2=rs2, alu_src_sel=src_imm, alu_ctrl=op. These stay registered and stable through WRITEBACK.
- EXECUTE: capture alu_result into wb_data and alu_zero into zero_flag.
- WRITEBACK: rf_waddr=rd. rf_we=1 for exactly this cycle, and only if wb_en=1 and op!=3'b111.
- DONE: done=1 for one cycle; retired increments and wraps 2^CNT_W-1 -> 0. Then return to IDLE.
- op=3'b111 is reserved. It runs the full sequence with rf_we suppressed, wb_data/zero_flag still updated, and illegal set. illegal clears only on reset.
- Reset, including mid-instruction: state IDLE, instr_ready=1. All other outputs 0: addresses, rf_we, alu_src_sel, alu_ctrl, wb_data, zero_flag, done, busy, illegal, retired. An in-flight instruction is abandoned with no write.

## Timing
- Handshake at cycle 0. DECODE at cycle 1, EXECUTE at 2, rf_we at 3, done at 4. instr_ready is high again at cycle 5, giving throughput of one instruction per 5 cycles.
- The ULA path is combinational from DECODE outputs, so it has one full cycle before the EXECUTE capture.
- instr_ready is a registered function of state and never depends combinationally on instr_valid.
- rf_we is registered and glitch-free; rf_waddr is stable in the same cycle.

## Configuration
- SEQ_STEP_EN defined:
  - Each transition out of DECODE, EXECUTE and WRITEBACK additionally requires step=1 in that cycle.
  - step is a one-cycle pulse produced upstream from a key edge.
  - IDLE->DECODE and DONE->IDLE are unaffected.
- SEQ_STEP_EN undefined: step is ignored, with timing exactly as above.

## Structure
- Shared package (seq_pkg):
  - State enum and its encodings.
  - Instruction field bit positions.
  - OP_RESERVED=3'b111.
  - ULAControl opcode constants shared with the ULA.
- Sub-module instr_decode: combinational unpacking of the latched instr into fields plus a legality bit.

## Test plan
- Reset, then instr=16'b010_011_001_010_0_1_00 (op 2, rd3, rs1 1, rs2 2, reg, wb): done at cycle 4, rf_we=1 at cycle 3 only with rf_waddr=3. With alu_result=8'h2A, wb_data=8'h2A; retired=1.
- src_imm=1, wb_en=0: alu_src_sel=1 during cycles 1-3; rf_we never asserts; done still pulses.
- op=3'b111, wb_en=1: no rf_we; illegal=1 and stays high through subsequent legal instructions until iRST_N pulse.
- alu_result=0, alu_zero=1 in EXECUTE: zero_flag=1 after cycle 2, held until next EXECUTE captures alu_zero=0.
- Assert iRST_N low during WRITEBACK: rf_we drops immediately, all outputs 0, state_dbg=0. After 256 completions, retired wraps to 0.
- With SEQ_STEP_EN, step held low: FSM holds DECODE indefinitely; each step pulse advances exactly one state.
